clb_config_loader: RTL and testbench



---
 rtl/clb_config_loader.sv | 110 +++++++++++
 tb/tb_clb_config_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/clb_config_loader.sv
// Serial configuration loader for one CLB: hunts for a preamble, deserializes
// a CFG_BITS word, checks even parity and presents the word with DONE/ERR status.
module clb_config_loader #(
  parameter int          CFG_BITS = 16,
  parameter logic [7:0]  PREAMBLE = 8'hA5
) (
  input  logic                K,
  input  logic                RN,
  input  logic                DIN,
  input  logic                DV,
  input  logic                CLR,
  output logic [CFG_BITS-1:0] CFG,
  output logic                DONE,
  output logic                ERR,
  output logic                BUSY
);

  localparam int CW = $clog2(CFG_BITS + 1);

  typedef enum logic [2:0] {
    ST_HUNT, ST_LOAD, ST_PARITY, ST_DONE, ST_ERR
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          win, win_nxt, win_sh;
  logic [3:0]          hcnt, hcnt_nxt, hcnt_inc;
  logic [CW-1:0]       bcnt, bcnt_nxt;
  logic [CFG_BITS-1:0] stage, stage_nxt;
  logic [CFG_BITS-1:0] cfg_nxt;
  logic                done_nxt, err_nxt, busy_nxt;

  always_ff @(posedge K or negedge RN) begin
    if (!RN) begin
      state <= ST_HUNT;
      win   <= '0;
      hcnt  <= '0;
      bcnt  <= '0;
      stage <= '0;
      CFG   <= '0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nxt;
      win   <= win_nxt;
      hcnt  <= hcnt_nxt;
      bcnt  <= bcnt_nxt;
      stage <= stage_nxt;
      CFG   <= cfg_nxt;
      DONE  <= done_nxt;
      ERR   <= err_nxt;
      BUSY  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    hcnt_nxt  = hcnt;
    bcnt_nxt  = bcnt;
    stage_nxt = stage;
    cfg_nxt   = CFG;
    done_nxt  = DONE;
    err_nxt   = ERR;
    // Window and count include the bit being accepted on this edge.
    win_sh    = {win[6:0], DIN};
    hcnt_inc  = (hcnt == 4'hF) ? hcnt : hcnt + 4'd1;

    if (CLR) begin
      // CFG survives a restart so the CLB keeps its last good configuration.
      state_nxt = ST_HUNT;
      win_nxt   = '0;
      hcnt_nxt  = '0;
      bcnt_nxt  = '0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
    end else if (DV) begin
      case (state)
        ST_HUNT: begin
          win_nxt  = win_sh;
          hcnt_nxt = hcnt_inc;
          if (win_sh == PREAMBLE && hcnt_inc >= 4'd8) begin
            state_nxt = ST_LOAD;
            bcnt_nxt  = '0;
            stage_nxt = '0;
          end
        end
        ST_LOAD: begin
          stage_nxt = {stage[CFG_BITS-2:0], DIN};
          bcnt_nxt  = bcnt + CW'(1);
          if (bcnt == CW'(CFG_BITS - 1)) state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          if ((^stage) == DIN) begin
            cfg_nxt   = stage;
            done_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_ERR;
          end
        end
        default: ;
      endcase
    end

    busy_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_PARITY);
  end

endmodule

// File: tb/tb_clb_config_loader.sv
// Bench for clb_config_loader: vector table, hand-written corner sequences and a
// randomized run against a bit-stream reference model.
module tb_clb_config_loader;
  localparam int N = 16;

  logic         K = 1'b0, RN = 1'b0, DIN = 1'b0, DV = 1'b0, CLR = 1'b0;
  logic [N-1:0] CFG;
  logic         DONE, ERR, BUSY;

  int errors = 0, checks = 0;

  clb_config_loader #(.CFG_BITS(N), .PREAMBLE(8'hA5)) dut (
    .K(K), .RN(RN), .DIN(DIN), .DV(DV), .CLR(CLR),
    .CFG(CFG), .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 K = ~K;

  // Reference model: all bits accepted since the last restart, evaluated from scratch.
  bit           q[$];
  logic         m_busy, m_done, m_err, m_complete;
  logic [N-1:0] m_cfg;

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_done = 0; m_err = 0; m_complete = 0; m_cfg = '0;
  endtask

  task automatic model_eval();
    logic [7:0]   w;
    logic [N-1:0] d;
    m_busy = 0; m_done = 0; m_err = 0; m_complete = 0;
    for (int i = 7; i < q.size(); i++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w = {w[6:0], q[i-7+j]};
      if (w == 8'hA5) begin
        if (q.size() - 1 - i < N + 1) m_busy = 1;
        else begin
          d = '0;
          for (int k = 0; k < N; k++) d = {d[N-2:0], q[i+1+k]};
          if (((^d) ^ q[i+1+N]) == 1'b0) begin m_done = 1; m_cfg = d; end
          else m_err = 1;
          m_complete = 1;
        end
        break;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic din, input logic dv, input logic clr);
    DIN = din; DV = dv; CLR = clr;
    @(posedge K);
    if (!RN) model_reset();
    else if (clr) q.delete();
    else if (dv && !m_complete) q.push_back(din);
    model_eval();
    #1;
  endtask

  task automatic send_frame(input logic [7:0] pre, input logic [N-1:0] data,
                            input logic par, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 7; i >= 0; i--) begin tick(pre[i], 1, 0); busy_cnt += int'(BUSY); end
    for (int i = N-1; i >= 0; i--) begin tick(data[i], 1, 0); busy_cnt += int'(BUSY); end
    tick(par, 1, 0); busy_cnt += int'(BUSY);
  endtask

  typedef struct {
    logic [N-1:0] data;
    logic         par;
    logic         exp_done;
    logic         exp_err;
    logic [N-1:0] exp_cfg;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int bc;
    logic [N-1:0] rd;
    tbl[0] = '{16'h3C5A, 1'b0, 1'b1, 1'b0, 16'h3C5A};
    tbl[1] = '{16'h3C5A, 1'b1, 1'b0, 1'b1, 16'h3C5A};
    tbl[2] = '{16'h0001, 1'b1, 1'b1, 1'b0, 16'h0001};
    tbl[3] = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 16'hFFFF};
    tbl[4] = '{16'h8000, 1'b0, 1'b0, 1'b1, 16'hFFFF};
    tbl[5] = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    model_reset();

    // Reset held with activity on the inputs
    for (int i = 0; i < 4; i++) tick(i[0], 1, 0);
    check("rst_cfg", CFG, 0); check("rst_done", DONE, 0);
    check("rst_err", ERR, 0); check("rst_busy", BUSY, 0);
    RN = 1'b1;
    repeat (5) tick(0, 0, 0);
    check("post_rst_out", {BUSY, DONE, ERR, CFG}, 0);

    // Bad parity straight after reset keeps CFG at 0
    send_frame(8'hA5, 16'h3C5A, 1'b1, bc);
    check("bad0_err", ERR, 1); check("bad0_done", DONE, 0); check("bad0_cfg", CFG, 0);
    tick(0, 0, 1);
    check("bad0_clr", {BUSY, DONE, ERR}, 0);

    for (int v = 0; v < 6; v++) begin
      tick(0, 0, 1);
      send_frame(8'hA5, tbl[v].data, tbl[v].par, bc);
      check($sformatf("tbl%0d_busycnt", v), bc, 17);
      check($sformatf("tbl%0d_done", v), DONE, tbl[v].exp_done);
      check($sformatf("tbl%0d_err", v), ERR, tbl[v].exp_err);
      check($sformatf("tbl%0d_cfg", v), CFG, tbl[v].exp_cfg);
    end

    // A second frame after DONE is ignored
    tick(0, 0, 1);
    send_frame(8'hA5, 16'h3C5A, 1'b0, bc);
    send_frame(8'hA5, 16'h1234, 1'b1, bc);
    check("hold_busycnt", bc, 0);
    check("hold_out", {BUSY, DONE, ERR, CFG}, {3'b010, 16'h3C5A});

    // Sliding hunt with gaps
    tick(0, 0, 1);
    begin
      logic [28:0] s;
      s = {4'b1101, 8'hA5, 16'hFFFF, 1'b0};
      for (int i = 28; i >= 0; i--) begin
        tick(s[i], 1, 0);
        if (i == 1) check("gap_pre_done", DONE, 0);
        if (i > 0) tick($urandom_range(0, 1), 0, 0);
      end
      check("gap_done", {DONE, ERR, BUSY}, 3'b100);
      check("gap_cfg", CFG, 16'hFFFF);
    end

    // Reset mid-load
    tick(0, 0, 1);
    for (int i = 7; i >= 0; i--) tick(bit'(8'hA5 >> i), 1, 0);
    for (int i = 0; i < 6; i++) tick(1, 1, 0);
    check("midload_busy", BUSY, 1);
    #2 RN = 1'b0; #1;
    model_reset();
    check("midload_rst", {BUSY, DONE, ERR, CFG}, 0);
    RN = 1'b1;
    send_frame(8'hA5, 16'h0001, 1'b1, bc);
    check("midload_frame", {BUSY, DONE, ERR, CFG}, {3'b010, 16'h0001});

    // CLR collides with the last preamble bit
    tick(0, 0, 1);
    bc = 0;
    for (int i = 7; i >= 1; i--) tick(bit'(8'hA5 >> i), 1, 0);
    tick(1, 1, 1);
    bc += int'(BUSY);
    for (int i = N-1; i >= 0; i--) begin tick(bit'(16'h3C5A >> i), 1, 0); bc += int'(BUSY); end
    tick(0, 1, 0); bc += int'(BUSY);
    check("coll_busycnt", bc, 0);
    check("coll_out", {BUSY, DONE, ERR, CFG}, {3'b000, 16'h0001});

    // Randomized frames, gaps and restarts against the model
    tick(0, 0, 1);
    for (int f = 0; f < 60; f++) begin
      logic [N-1:0] d;
      logic [7:0]   jn;
      int           nj;
      logic [N+8:0] s;
      d  = N'($urandom);
      nj = $urandom_range(0, 5);
      jn = 8'($urandom);
      s  = {8'hA5, d, (^d) ^ ($urandom_range(0, 3) == 0)};
      for (int i = nj - 1; i >= 0; i--) begin
        tick(jn[i], 1, 0);
        check("rnd", {BUSY, DONE, ERR, CFG}, {m_busy, m_done, m_err, m_cfg});
      end
      for (int i = N + 8; i >= 0; i--) begin
        repeat ($urandom_range(0, 2)) begin
          tick($urandom_range(0, 1), 0, 0);
          check("rnd", {BUSY, DONE, ERR, CFG}, {m_busy, m_done, m_err, m_cfg});
        end
        tick(s[i], 1, ($urandom_range(0, 79) == 0));
        check("rnd", {BUSY, DONE, ERR, CFG}, {m_busy, m_done, m_err, m_cfg});
      end
      if ($urandom_range(0, 4) != 0) begin
        tick($urandom_range(0, 1), $urandom_range(0, 1), 1);
        check("rnd_clr", {BUSY, DONE, ERR, CFG}, {m_busy, m_done, m_err, m_cfg});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
